// File: rtl/mini_cpu.sv
// Single-cycle 8-bit CPU: 24-bit instructions from a combinational ROM,
// eight 8-bit registers, byte-wide data RAM, absolute jumps and HALT.
module mini_cpu (
  input  logic        clk,
  input  logic        rst_,
  output logic [7:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_d_in,
  input  logic [7:0]  ram_d_out,
  output logic        ram_rd_,
  output logic        ram_wr_
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR = 4'h8, OP_MOV = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
    OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_JNZ = 4'hE, OP_HALT = 4'hF
  } op_e;

  logic [7:0]      pc_q, pc_d;
  logic [7:0][7:0] rf_q;

  op_e        op;
  logic [2:0] rd_idx, ra_idx, rb_idx;
  logic [7:0] imm, a_val, b_val;
  logic       rf_we;
  logic [7:0] rf_wd;
  logic       is_ld, is_st;

  logic unused_bits;
  assign unused_bits = ^{rom_data[19], rom_data[15], rom_data[11]};

  assign op     = op_e'(rom_data[23:20]);
  assign rd_idx = rom_data[18:16];
  assign ra_idx = rom_data[14:12];
  assign rb_idx = rom_data[10:8];
  assign imm    = rom_data[7:0];

  // Operands are read from the current register state, so rd==ra/rb sees the old value.
  assign a_val = rf_q[ra_idx];
  assign b_val = rf_q[rb_idx];

  assign rom_addr = pc_q;

  always_comb begin
    pc_d  = pc_q + 8'd1;
    rf_we = 1'b0;
    rf_wd = 8'h00;
    is_ld = 1'b0;
    is_st = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_LDI:  begin rf_we = 1'b1; rf_wd = imm; end
      OP_LD:   begin rf_we = 1'b1; rf_wd = ram_d_out; is_ld = 1'b1; end
      OP_ST:   is_st = 1'b1;
      OP_ADD:  begin rf_we = 1'b1; rf_wd = a_val + b_val; end
      OP_SUB:  begin rf_we = 1'b1; rf_wd = a_val - b_val; end
      OP_AND:  begin rf_we = 1'b1; rf_wd = a_val & b_val; end
      OP_OR:   begin rf_we = 1'b1; rf_wd = a_val | b_val; end
      OP_XOR:  begin rf_we = 1'b1; rf_wd = a_val ^ b_val; end
      OP_MOV:  begin rf_we = 1'b1; rf_wd = a_val; end
      OP_SHL:  begin rf_we = 1'b1; rf_wd = {a_val[6:0], 1'b0}; end
      OP_SHR:  begin rf_we = 1'b1; rf_wd = {1'b0, a_val[7:1]}; end
      OP_JMP:  pc_d = imm;
      OP_JZ:   if (a_val == 8'h00) pc_d = imm;
      OP_JNZ:  if (a_val != 8'h00) pc_d = imm;
      OP_HALT: pc_d = pc_q;
      default: ;
    endcase
  end

  // RAM strobes are qualified by rst_ so a reset during ST kills the write at once.
  always_comb begin
    ram_rd_  = 1'b1;
    ram_wr_  = 1'b1;
    ram_addr = 8'h00;
    ram_d_in = 8'h00;
    if (rst_ && is_ld) begin
      ram_rd_  = 1'b0;
      ram_addr = imm;
    end
    if (rst_ && is_st) begin
      ram_wr_  = 1'b0;
      ram_addr = imm;
      ram_d_in = a_val;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc_q <= 8'h00;
      rf_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (rf_we) rf_q[rd_idx] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mini_cpu.sv
// Bench for mini_cpu: bench-side ROM/RAM, an instruction-level reference
// model, per-cycle output comparison, directed programs and random programs.
module tb_mini_cpu;

  logic        clk, rst_;
  logic [7:0]  rom_addr, ram_addr, ram_d_in, ram_d_out;
  logic [23:0] rom_data;
  logic        ram_rd_, ram_wr_;

  mini_cpu dut (
    .clk(clk), .rst_(rst_),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out),
    .ram_rd_(ram_rd_), .ram_wr_(ram_wr_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] rom [256];
  logic [7:0]  ram [256];
  assign rom_data  = rom[rom_addr];
  assign ram_d_out = ram_rd_ ? 8'h00 : ram[ram_addr];
  always @(posedge clk) if (!ram_wr_) ram[ram_addr] <= ram_d_in;

  // Reference model: architectural state stepped one instruction per edge
  int          mpc;
  logic [7:0]  mreg [8];
  logic [7:0]  mmem [256];
  int          exec_cnt [256];
  int          n_chk = 0, n_fail = 0;
  bit          cmp_en = 1'b0;
  logic [23:0] prog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ins(input int op, input int rd, input int ra,
                                      input int rb, input int imm);
    logic [3:0] o; logic [2:0] d, a, b; logic [7:0] i;
    o = op[3:0]; d = rd[2:0]; a = ra[2:0]; b = rb[2:0]; i = imm[7:0];
    return {o, 1'b0, d, 1'b0, a, 1'b0, b, i};
  endfunction

  task automatic model_reset();
    mpc = 0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
  endtask

  task automatic model_exec();
    logic [23:0] w;
    int op, nxt;
    logic [7:0] a, b, imm;
    w   = rom[mpc];
    op  = int'(w[23:20]);
    a   = mreg[w[14:12]];
    b   = mreg[w[10:8]];
    imm = w[7:0];
    nxt = (mpc + 1) % 256;
    exec_cnt[mpc]++;
    case (op)
      1:  mreg[w[18:16]] = imm;
      2:  mreg[w[18:16]] = mmem[imm];
      3:  mmem[imm] = a;
      4:  mreg[w[18:16]] = 8'((int'(a) + int'(b)) % 256);
      5:  mreg[w[18:16]] = 8'((int'(a) - int'(b) + 256) % 256);
      6:  mreg[w[18:16]] = a & b;
      7:  mreg[w[18:16]] = a | b;
      8:  mreg[w[18:16]] = a ^ b;
      9:  mreg[w[18:16]] = a;
      10: mreg[w[18:16]] = 8'((int'(a) * 2) % 256);
      11: mreg[w[18:16]] = 8'(int'(a) / 2);
      12: nxt = int'(imm);
      13: if (a == 8'h00) nxt = int'(imm);
      14: if (a != 8'h00) nxt = int'(imm);
      15: nxt = mpc;
      default: ;
    endcase
    mpc = nxt;
  endtask

  always @(posedge clk) if (!rst_) model_reset(); else model_exec();
  always @(negedge rst_) model_reset();

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [23:0] w;
      logic [7:0] e_addr, e_din, e_pc;
      logic e_rd, e_wr;
      w = rom[mpc];
      e_pc = 8'(mpc);
      e_rd = 1'b1; e_wr = 1'b1; e_addr = 8'h00; e_din = 8'h00;
      if (rst_ && w[23:20] == 4'h2) begin e_rd = 1'b0; e_addr = w[7:0]; end
      if (rst_ && w[23:20] == 4'h3) begin
        e_wr = 1'b0; e_addr = w[7:0]; e_din = mreg[w[14:12]];
      end
      chk("outputs{pc,addr,din,rd_,wr_}",
          {14'h0, rom_addr, ram_addr, ram_d_in, ram_rd_, ram_wr_},
          {14'h0, e_pc, e_addr, e_din, e_rd, e_wr});
      chk("rd_wr_exclusive", {31'h0, ram_rd_ | ram_wr_}, 32'h1);
    end
  end

  // Load prog under reset with fresh random RAM, then release mid-cycle
  task automatic start();
    @(posedge clk); #3;
    rst_ = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      rom[i] = (i < prog.size()) ? prog[i] : 24'h0;
      ram[i] = r; mmem[i] = r;
      exec_cnt[i] = 0;
    end
    @(posedge clk); #3;
    rst_ = 1'b1;
  endtask

  task automatic run_until(input int pc, input int budget);
    int k;
    k = 0;
    while (rom_addr !== 8'(pc) && k < budget) begin
      @(negedge clk); k++;
    end
    chk("reach_pc", {24'h0, rom_addr}, pc);
  endtask

  initial begin
    logic [7:0] old;
    rst_ = 1'b0;
    for (int i = 0; i < 256; i++) begin rom[i] = 24'h0; ram[i] = 8'h0; mmem[i] = 8'h0; end
    model_reset();
    #2;
    chk("reset_rom_addr", {24'h0, rom_addr}, 0);
    chk("reset_ram_strobes", {30'h0, ram_rd_, ram_wr_}, 32'h3);
    chk("reset_ram_bus", {16'h0, ram_addr, ram_d_in}, 0);
    cmp_en = 1'b1;

    // Add then halt; PC must sit at the HALT
    prog = {ins(1,1,0,0,5), ins(1,2,0,0,3), ins(4,3,1,2,0), ins(15,0,0,0,0)};
    start();
    run_until(3, 20);
    chk("add_r3_model", {24'h0, mreg[3]}, 8);
    repeat (3) begin @(negedge clk); chk("halt_hold_pc", {24'h0, rom_addr}, 3); end

    // Wrap-around on add and subtract
    prog = {ins(1,1,0,0,8'hFF), ins(1,2,0,0,1), ins(4,3,1,2,0), ins(5,4,3,2,0),
            ins(3,0,3,0,8'h20), ins(3,0,4,0,8'h21), ins(15,0,0,0,0)};
    start();
    run_until(6, 20);
    chk("wrap_add_ram", {24'h0, ram[8'h20]}, 8'h00);
    chk("wrap_sub_ram", {24'h0, ram[8'h21]}, 8'hFF);
    chk("wrap_sub_model", {24'h0, mreg[4]}, 8'hFF);

    // Store then load back
    prog = {ins(1,1,0,0,8'h5A), ins(3,0,1,0,8'h10), ins(2,2,0,0,8'h10),
            ins(3,0,2,0,8'h11), ins(15,0,0,0,0)};
    start();
    run_until(1, 10);
    chk("st_cycle_bus", {15'h0, ram_wr_, ram_addr, ram_d_in}, {15'h0, 1'b0, 8'h10, 8'h5A});
    run_until(4, 10);
    chk("ld_roundtrip_ram", {24'h0, ram[8'h11]}, 8'h5A);
    chk("ld_model_r2", {24'h0, mreg[2]}, 8'h5A);

    // Countdown loop
    prog = {ins(1,1,0,0,3), ins(1,2,0,0,1), ins(5,1,1,2,0), ins(14,0,1,0,2), ins(15,0,0,0,0)};
    start();
    run_until(4, 40);
    chk("loop_sub_count", exec_cnt[2], 3);
    chk("loop_r1_model", {24'h0, mreg[1]}, 0);

    // Taken JZ then shifts of 0x81
    prog = {ins(13,0,0,0,5), ins(1,7,0,0,8'hEE), ins(1,7,0,0,8'hEE), ins(1,7,0,0,8'hEE),
            ins(1,7,0,0,8'hEE), ins(1,1,0,0,8'h81), ins(10,2,1,0,0), ins(11,3,1,0,0),
            ins(3,0,2,0,8'h30), ins(3,0,3,0,8'h31), ins(15,0,0,0,0)};
    start();
    run_until(10, 30);
    chk("shl_ram", {24'h0, ram[8'h30]}, 8'h02);
    chk("shr_ram", {24'h0, ram[8'h31]}, 8'h40);
    chk("jz_skipped", exec_cnt[1], 0);

    // Reset asserted during a store: no write, async clear, clean restart
    prog = {ins(3,0,5,0,8'h41), ins(1,1,0,0,8'h77), ins(1,5,0,0,9),
            ins(3,0,1,0,8'h40), ins(15,0,0,0,0)};
    start();
    old = ram[8'h40];
    run_until(3, 10);
    #2 rst_ = 1'b0;
    #1;
    chk("rst_kills_wr", {31'h0, ram_wr_}, 1);
    chk("rst_async_pc", {24'h0, rom_addr}, 0);
    @(posedge clk); #1;
    chk("rst_no_write", {24'h0, ram[8'h40]}, {24'h0, old});
    @(posedge clk); #2 rst_ = 1'b1;
    run_until(4, 10);
    chk("rst_regs_cleared", {24'h0, ram[8'h41]}, 0);
    chk("rst_restart_store", {24'h0, ram[8'h40]}, 8'h77);

    // Random programs, some with a reset pulse mid-run
    for (int p = 0; p < 8; p++) begin
      int rst_at;
      prog = {};
      for (int i = 0; i < 64; i++) begin
        int op, imm;
        logic [23:0] w;
        op  = $urandom_range(0, 14);
        imm = (op >= 12) ? $urandom_range(0, 63) : $urandom_range(0, 255);
        w = ins(op, $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), imm);
        w[19] = 1'($urandom); w[15] = 1'($urandom); w[11] = 1'($urandom);
        prog.push_back(w);
      end
      if (p % 2 == 0) prog[63] = ins(15,0,0,0,0);
      start();
      rst_at = (p % 3 == 1) ? $urandom_range(20, 250) : -1;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (c == rst_at) begin
          #2 rst_ = 1'b0;
          @(posedge clk); @(posedge clk); #3 rst_ = 1'b1;
        end
      end
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
